// File: rtl/rate_divider.sv
// Programmable rate divider: emits a one-cycle pulse every P(sel) enabled clock
// edges, with pause/resume that preserves the remaining count.
module rate_divider #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CW     = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    sel,
  output logic          pulse,
  output logic [CW-1:0] count,
  output logic          running
);

  localparam logic [CW-1:0] RELOAD_1X = CW'(64'(CLK_HZ) - 64'd1);
  localparam logic [CW-1:0] RELOAD_2X = CW'(64'(CLK_HZ) * 64'd2 - 64'd1);
  localparam logic [CW-1:0] RELOAD_4X = CW'(64'(CLK_HZ) * 64'd4 - 64'd1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] sel_q;

  // Reload value is period minus one: the terminal edge at count==0 is itself
  // one of the P edges.
  function automatic logic [CW-1:0] reload(input logic [1:0] s);
    logic [CW-1:0] r;
    r = '0;
    case (s)
      2'b00:   r = '0;
      2'b01:   r = RELOAD_1X;
      2'b10:   r = RELOAD_2X;
      default: r = RELOAD_4X;
    endcase
    return r;
  endfunction

  assign running = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pulse <= 1'b0;
      sel_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          sel_q <= sel;
          if (enable) begin
            state <= RUN;
            count <= reload(sel);
            pulse <= 1'b0;
          end
        end
        default: begin
          if (sel != sel_q) begin
            sel_q <= sel;
            count <= reload(sel);
            pulse <= 1'b0;
          end else if (!enable) begin
            pulse <= 1'b0;
          end else if (count != '0) begin
            count <= count - 1'b1;
            pulse <= 1'b0;
          end else begin
            count <= reload(sel_q);
            pulse <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rate_divider.sv
// Self-checking bench for rate_divider: directed scenarios with literal
// expectations plus randomized traffic checked against an elapsed-edge model.
module tb_rate_divider;

  localparam int unsigned HZ = 4;
  localparam int unsigned W  = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   sel;
  logic         pulse;
  logic [W-1:0] count;
  logic         running;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Model: running flag, active selection, enabled edges elapsed in the period.
  bit         m_run;
  logic [1:0] m_selq;
  int         m_el;
  bit         m_pulse;

  always #5 clk = ~clk;

  rate_divider #(.CLK_HZ(HZ), .CW(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sel(sel),
    .pulse(pulse), .count(count), .running(running)
  );

  function automatic int per(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return HZ;
      2'b10:   return 2 * HZ;
      default: return 4 * HZ;
    endcase
  endfunction

  function automatic int m_count();
    return m_run ? per(m_selq) - 1 - m_el : 0;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_selq = 2'b00; m_el = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [1:0] s);
    if (reset) model_reset();
    else if (!m_run) begin
      m_selq = s;
      if (en) begin m_run = 1'b1; m_el = 0; m_pulse = 1'b0; end
    end else if (s != m_selq) begin
      m_selq = s; m_el = 0; m_pulse = 1'b0;
    end else if (!en) m_pulse = 1'b0;
    else if (m_el == per(m_selq) - 1) begin
      m_el = 0; m_pulse = 1'b1;
    end else begin
      m_el = m_el + 1; m_pulse = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_count", int'(count), m_count());
      chk("cmp_pulse", int'(pulse), int'(m_pulse));
      chk("cmp_running", int'(running), int'(m_run));
    end
  end

  // Drives inputs, lets one rising edge pass, and returns just after the
  // following falling edge so checks see settled post-edge values.
  task automatic cyc(input bit en, input logic [1:0] s);
    enable = en; sel = s;
    @(posedge clk);
    model_step(en, s);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_pulse"}, int'(pulse), 0);
  endtask

  initial begin
    int npulse;
    int dbl;
    bit prev;
    reset = 1'b1; enable = 1'b0; sel = 2'b00;
    model_reset();
    cmp_on = 1'b1;
    cyc(0, 2'b00);
    cyc(0, 2'b00);
    chk("rst_count", int'(count), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_pulse", int'(pulse), 0);
    reset = 1'b0;

    // Basic 1x rate: load 3, count down, pulse with reload every 4 edges.
    cyc(1, 2'b01);
    chk("r27_run", int'(running), 1);
    chk("r27_load", int'(count), 3);
    for (int i = 2; i >= 0; i--) begin
      cyc(1, 2'b01);
      chk("r27_down", int'(count), i);
      chk("r27_nopulse", int'(pulse), 0);
    end
    cyc(1, 2'b01);
    chk("r27_pulse", int'(pulse), 1);
    chk("r27_reload", int'(count), 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b01);
      chk("r27_gap", int'(pulse), 0);
    end
    cyc(1, 2'b01);
    chk("r27_pulse2", int'(pulse), 1);

    // Reset mid-count aborts the period.
    cyc(1, 2'b01);
    chk("r31_pre", int'(count), 2);
    async_reset_check("r31");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b01);
      chk("r31_held_pulse", int'(pulse), 0);
      chk("r31_held_run", int'(running), 0);
    end
    reset = 1'b0;

    // Fastest rate: pulse on every edge after entering RUN.
    cyc(1, 2'b00);
    chk("r28_run", int'(running), 1);
    chk("r28_first", int'(pulse), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'b00);
      chk("r28_pulse", int'(pulse), 1);
    end

    // Rate change in RUN reloads immediately.
    cyc(1, 2'b10);
    chk("r30_load2x", int'(count), 7);
    cyc(1, 2'b10);
    cyc(1, 2'b10);
    chk("r30_at5", int'(count), 5);
    cyc(1, 2'b01);
    chk("r30_reload", int'(count), 3);
    chk("r30_nopulse", int'(pulse), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b01);
      chk("r30_gap", int'(pulse), 0);
    end
    cyc(1, 2'b01);
    chk("r30_pulse", int'(pulse), 1);

    // Pause preserves count; pulse after remaining count+1 enabled edges.
    cyc(1, 2'b11);
    chk("r29_load4x", int'(count), 15);
    for (int i = 0; i < 6; i++) cyc(1, 2'b11);
    chk("r29_at9", int'(count), 9);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b11);
      chk("r29_hold", int'(count), 9);
      chk("r29_hold_pulse", int'(pulse), 0);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1, 2'b11);
      chk("r29_gap", int'(pulse), 0);
    end
    cyc(1, 2'b11);
    chk("r29_pulse", int'(pulse), 1);
    chk("r29_reload", int'(count), 15);

    // 40 enabled cycles from IDLE at 1x: nine single-cycle pulses.
    async_reset_check("r32_rst");
    cyc(0, 2'b01);
    reset = 1'b0;
    npulse = 0; dbl = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 2'b01);
      if (pulse) npulse++;
      if (pulse && prev) dbl++;
      prev = pulse;
    end
    chk("r32_npulse", npulse, 9);
    chk("r32_width", dbl, 0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] s;
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        async_reset_check("rnd_rst");
        for (int k = 0; k < int'($urandom_range(1, 3)); k++)
          cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        reset = 1'b0;
      end else begin
        s = sel;
        if ($urandom_range(0, 19) == 0) s = 2'($urandom_range(0, 3));
        cyc($urandom_range(0, 9) < 8, s);
      end
    end

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_divider.md
RATE_DIVIDER -- requirements
Module: rate_divider

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, input clock frequency in Hz; sets the base tick period.
REQ-002 Parameter: CW, default 28, counter width in bits; SHALL satisfy 2^CW >= 4*CLK_HZ.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  run/pause control; high = count down, low = hold.
REQ-006 Port: sel  input  2  rate select.
REQ-007 Port: pulse  output  1  registered one-cycle tick; drives the downstream 8-bit counter's enable.
REQ-008 Port: count  output  CW  current down-counter value, for observation.
REQ-009 Port: running  output  1  high when the FSM is in RUN.

Function
REQ-010 Period P(sel) SHALL be: 00 -> 1, 01 -> CLK_HZ, 10 -> 2*CLK_HZ, 11 -> 4*CLK_HZ clock cycles.
REQ-011 The FSM SHALL have exactly two states, IDLE and RUN; running = (state == RUN).
REQ-012 Register sel_q SHALL hold the sel value in effect.
REQ-013 IDLE, enable=0: count, pulse and state hold; sel_q <= sel.
REQ-014 IDLE, enable=1: state <= RUN, count <= P(sel)-1, sel_q <= sel, pulse <= 0.
REQ-015 RUN, sel != sel_q (highest priority, independent of enable): count <= P(sel)-1, sel_q <= sel, pulse <= 0.
REQ-016 RUN, sel == sel_q, enable=0: count holds, pulse <= 0.
REQ-017 RUN, sel == sel_q, enable=1, count != 0: count <= count-1, pulse <= 0.
REQ-018 RUN, sel == sel_q, enable=1, count == 0: pulse <= 1, count <= P(sel_q)-1.
REQ-019 pulse SHALL be high for exactly one cycle per terminal event, except sel=00 with enable held high, where it SHALL stay high every cycle.
REQ-020 With enable held high and sel stable, the first pulse SHALL occur P edges after the IDLE->RUN edge, then every P cycles.
REQ-021 Pausing SHALL preserve count; on resume, the pulse SHALL occur after exactly the remaining count+1 enabled edges.
REQ-022 RUN SHALL never return to IDLE except via reset.
REQ-023 count SHALL never wrap below 0; no arithmetic SHALL exceed CW bits.

Reset
REQ-024 reset high SHALL asynchronously force state=IDLE, count=0, pulse=0, sel_q=00, running=0.
REQ-025 Reset asserted mid-count SHALL abort the period immediately with no pulse generated.
REQ-026 After reset deasserts, behaviour SHALL resume from IDLE per REQ-013/014.

Verification (bench uses CLK_HZ=4)
REQ-027 Reset pulse, then sel=01, enable=1 -> edge1 running=1, count=3; count 2,1,0 on edges 2-4; pulse=1, count=3 on edge 5; repeats every 4 cycles.
REQ-028 sel=00, enable=1 from IDLE -> running=1 at edge1; pulse=1 on every edge from edge2 onward.
REQ-029 sel=11, enable=1; drop enable for 5 cycles at count=9 -> count stays 9, pulse=0; after re-enable, pulse 10 edges later.
REQ-030 sel=10 in RUN at count=5; change sel to 01 -> next edge count=3, pulse=0; pulse 4 edges later.
REQ-031 Assert reset at count=2 in RUN (sel=01) -> immediately count=0, running=0, pulse=0; no pulse while reset is held.
REQ-032 sel=01 with enable high for 40 cycles -> exactly 9 pulses, each exactly one cycle wide.
